// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// the fill word used for unloaded/out-of-range fetches and byte-lane helpers.
package imem_pkg;

  // Load FSM states: two header bytes, the data stream, then CPU execution.
  typedef enum logic [1:0] {
    HDR_LO = 2'd0,
    HDR_HI = 2'd1,
    DATA   = 2'd2,
    RUN    = 2'd3
  } load_state_e;

  // addi x0,x0,0 -- harmless instruction returned when no valid word exists.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // The byte stream packs four little-endian bytes per instruction word.
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  // Shift a new byte in from the top; after four bytes the first one
  // received sits in bits [7:0], giving little-endian assembly.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] acc,
                                                input logic [7:0]  new_byte);
    return {new_byte, acc[31:8]};
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port driven by the loader and
// one asynchronous read port serving the CPU fetch path (distributed RAM).
module imem_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [DEPTH];

  // Write port: contents persist across reset and reload on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory responder for the CPU fetch port. Fills itself from an
// 8-bit valid/ready boot stream (16-bit little-endian word count followed by
// little-endian words), holds the CPU in reset while loading and serves
// combinational fetches once the image is complete.
module imem_loader #(
  parameter int          DEPTH    = 1024,
  parameter int          ADDR_W   = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_out,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  import imem_pkg::*;

  // Saturation limit for words_loaded and overflow limit for the header count.
  localparam logic [ADDR_W:0] DEPTH_WL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [16:0]     DEPTH_HDR = 17'(DEPTH);

  // Load FSM and datapath registers.
  load_state_e         state_r, state_n;
  logic [7:0]          cnt_lo_r, cnt_lo_n;
  logic [15:0]         remaining_r, remaining_n;
  logic [LANE_W-1:0]   lane_r, lane_n;
  logic [31:0]         asm_r, asm_n;
  logic [ADDR_W:0]     words_loaded_r, words_loaded_n;
  logic                load_err_r, load_err_n;

  // Status outputs are registered from the next state so they change
  // exactly when the state does.
  logic                in_ready_r, in_ready_n;
  logic                cpu_rst_r, cpu_rst_n;
  logic                load_done_r, load_done_n;

  // Combinational helpers.
  logic                xfer_s;
  logic                we_s;
  logic [15:0]         hdr_count_s;
  logic [31:0]         wdata_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [ADDR_W-1:0]   raddr_s;
  logic [31:0]         rdata_s;
  logic                addr_hi_zero_s;
  logic                index_valid_s;
  logic [31:0]         imem_out_s;
  logic                unused_addr_bits_s;

  assign xfer_s      = in_valid && in_ready_r;
  assign hdr_count_s = {in_data, cnt_lo_r};
  assign wdata_s     = shift_in_byte(asm_r, in_data);
  assign waddr_s     = words_loaded_r[ADDR_W-1:0];

  // Fetch index is the word part of the byte address; the byte offset is
  // ignored so misaligned fetches read the containing word.
  assign raddr_s            = imem_addr[ADDR_W+1:2];
  assign unused_addr_bits_s = ^imem_addr[1:0];

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next-state logic: reload wins over any byte on the same edge.
  always_comb begin
    state_n        = state_r;
    cnt_lo_n       = cnt_lo_r;
    remaining_n    = remaining_r;
    lane_n         = lane_r;
    asm_n          = asm_r;
    words_loaded_n = words_loaded_r;
    load_err_n     = load_err_r;
    we_s           = 1'b0;

    if (reload) begin
      state_n        = HDR_LO;
      lane_n         = {LANE_W{1'b0}};
      asm_n          = 32'h0000_0000;
      words_loaded_n = {(ADDR_W + 1){1'b0}};
      load_err_n     = 1'b0;
    end else if (xfer_s) begin
      case (state_r)
        HDR_LO: begin
          cnt_lo_n = in_data;
          state_n  = HDR_HI;
        end
        HDR_HI: begin
          remaining_n = hdr_count_s;
          if ({1'b0, hdr_count_s} > DEPTH_HDR) begin
            load_err_n = 1'b1;
          end else begin
            load_err_n = load_err_r;
          end
          if (hdr_count_s == 16'd0) begin
            state_n = RUN;
          end else begin
            state_n = DATA;
          end
        end
        DATA: begin
          asm_n  = wdata_s;
          lane_n = lane_r + LANE_W'(1);
          if (lane_r == LAST_LANE) begin
            remaining_n = remaining_r - 16'd1;
            // Words beyond the memory are consumed but not stored.
            if (words_loaded_r < DEPTH_WL) begin
              we_s           = 1'b1;
              words_loaded_n = words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
              we_s           = 1'b0;
              words_loaded_n = words_loaded_r;
            end
            if (remaining_r == 16'd1) begin
              state_n = RUN;
            end else begin
              state_n = DATA;
            end
          end else begin
            remaining_n = remaining_r;
          end
        end
        RUN: begin
          state_n = RUN;
        end
        default: begin
          state_n = HDR_LO;
        end
      endcase
    end else begin
      state_n = state_r;
    end

    in_ready_n  = (state_n != RUN);
    cpu_rst_n   = (state_n != RUN);
    load_done_n = (state_n == RUN);
  end

  // State and counter registers with synchronous reset; memory is untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= HDR_LO;
      cnt_lo_r       <= 8'h00;
      remaining_r    <= 16'h0000;
      lane_r         <= {LANE_W{1'b0}};
      asm_r          <= 32'h0000_0000;
      words_loaded_r <= {(ADDR_W + 1){1'b0}};
      load_err_r     <= 1'b0;
      in_ready_r     <= 1'b1;
      cpu_rst_r      <= 1'b1;
      load_done_r    <= 1'b0;
    end else begin
      state_r        <= state_n;
      cnt_lo_r       <= cnt_lo_n;
      remaining_r    <= remaining_n;
      lane_r         <= lane_n;
      asm_r          <= asm_n;
      words_loaded_r <= words_loaded_n;
      load_err_r     <= load_err_n;
      in_ready_r     <= in_ready_n;
      cpu_rst_r      <= cpu_rst_n;
      load_done_r    <= load_done_n;
    end
  end

  assign addr_hi_zero_s = (imem_addr[31:ADDR_W+2] == {(30 - ADDR_W){1'b0}});
  assign index_valid_s  = ({1'b0, raddr_s} < words_loaded_r);

  // Fetch mux: only words written in the current load are visible, and only
  // once the CPU is running.
  always_comb begin
    imem_out_s = NOP_WORD;
    if ((state_r == RUN) && addr_hi_zero_s && index_valid_s) begin
      imem_out_s = rdata_s;
    end else begin
      imem_out_s = NOP_WORD;
    end
  end

  assign imem_out     = imem_out_s;
  assign in_ready     = in_ready_r;
  assign cpu_rst      = cpu_rst_r;
  assign load_done    = load_done_r;
  assign load_err     = load_err_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (DEPTH=1024 and DEPTH=4) share one
// stimulus stream; a stream-level model predicts every output each cycle.
module tb_imem_loader;

  localparam int          DA  = 1024;
  localparam int          DB  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;
  logic [31:0] imem_addr = 32'h0;

  logic        a_in_ready, a_cpu_rst, a_load_done, a_load_err;
  logic [31:0] a_imem_out;
  logic [10:0] a_wl;
  logic        b_in_ready, b_cpu_rst, b_load_done, b_load_err;
  logic [31:0] b_imem_out;
  logic [2:0]  b_wl;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .reload(reload), .imem_addr(imem_addr),
    .imem_out(a_imem_out), .cpu_rst(a_cpu_rst), .load_done(a_load_done),
    .load_err(a_load_err), .words_loaded(a_wl)
  );

  imem_loader #(.DEPTH(DB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .reload(reload), .imem_addr(imem_addr),
    .imem_out(b_imem_out), .cpu_rst(b_cpu_rst), .load_done(b_load_done),
    .load_err(b_load_err), .words_loaded(b_wl)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Model: bytes accepted since the last reset/reload, the header count,
  // the partial word and the memory image, per instance.
  int          m_cnt  [2];
  int          m_n    [2];
  logic [7:0]  m_lo   [2];
  logic [31:0] m_part [2];
  bit          m_err  [2];
  logic [31:0] m_mem  [2][DA];

  function automatic int m_depth(int d);
    return (d == 0) ? DA : DB;
  endfunction

  function automatic bit m_run(int d);
    return (m_cnt[d] >= 2) && (m_cnt[d] == 2 + 4 * m_n[d]);
  endfunction

  function automatic int m_wl(int d);
    int w;
    if (m_cnt[d] < 2) return 0;
    w = (m_cnt[d] - 2) / 4;
    return (w > m_depth(d)) ? m_depth(d) : w;
  endfunction

  function automatic logic [31:0] m_out(int d, logic [31:0] addr);
    int w;
    if (!m_run(d)) return NOP;
    w = int'(addr >> 2);
    if (w < m_wl(d)) return m_mem[d][w];
    return NOP;
  endfunction

  task automatic m_step();
    for (int d = 0; d < 2; d++) begin
      if (rst || reload) begin
        m_cnt[d]  = 0;
        m_n[d]    = 0;
        m_part[d] = 32'h0;
        m_err[d]  = 1'b0;
      end else if (in_valid && !m_run(d)) begin
        if (m_cnt[d] == 0) begin
          m_lo[d] = in_data;
        end else if (m_cnt[d] == 1) begin
          m_n[d]   = int'({in_data, m_lo[d]});
          m_err[d] = (m_n[d] > m_depth(d));
        end else begin
          int lane;
          int k;
          lane = (m_cnt[d] - 2) % 4;
          k    = (m_cnt[d] - 2) / 4;
          m_part[d] = m_part[d] | (32'(in_data) << (8 * lane));
          if (lane == 3) begin
            if (k < m_depth(d)) m_mem[d][k] = m_part[d];
            m_part[d] = 32'h0;
          end
        end
        m_cnt[d]++;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a_in_ready",  32'(a_in_ready),  32'(!m_run(0)));
    check("a_cpu_rst",   32'(a_cpu_rst),   32'(!m_run(0)));
    check("a_load_done", 32'(a_load_done), 32'(m_run(0)));
    check("a_load_err",  32'(a_load_err),  32'(m_err[0]));
    check("a_words",     32'(a_wl),        32'(m_wl(0)));
    check("a_imem_out",  a_imem_out,       m_out(0, imem_addr));
    check("b_in_ready",  32'(b_in_ready),  32'(!m_run(1)));
    check("b_cpu_rst",   32'(b_cpu_rst),   32'(!m_run(1)));
    check("b_load_done", 32'(b_load_done), 32'(m_run(1)));
    check("b_load_err",  32'(b_load_err),  32'(m_err[1]));
    check("b_words",     32'(b_wl),        32'(m_wl(1)));
    check("b_imem_out",  b_imem_out,       m_out(1, imem_addr));
  endtask

  // Model follows each clock edge using the inputs held across it.
  initial forever begin
    @(posedge clk);
    m_step();
  end

  // Per-cycle comparison on the falling edge.
  initial forever begin
    @(negedge clk);
    if (checking) compare_all();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[7:0]);
      t = t >> 8;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic probe(string name, logic [31:0] addr, logic [31:0] exp_a, logic [31:0] exp_b);
    tick();
    imem_addr = addr;
    #1;
    check({name, "_a"}, a_imem_out, exp_a);
    check({name, "_b"}, b_imem_out, exp_b);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 40));
  endfunction

  logic [31:0] words5 [5];

  initial begin
    rst = 1'b1;
    tick();
    checking = 1'b1;
    rst = 1'b0;
    check("rst_words",    32'(a_wl), 32'd0);
    check("rst_cpu_rst",  32'(a_cpu_rst), 32'd1);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);

    // Two-word image with a 3-cycle valid gap mid-word.
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h00);
    probe("load_probe", 32'h0, NOP, NOP);
    check("load_cpu_rst", 32'(a_cpu_rst), 32'd1);
    tick(); tick();
    send_byte(8'h7D);
    send_byte(8'h93); send_byte(8'h80); send_byte(8'h00);
    check("pre_last_cpu_rst", 32'(a_cpu_rst), 32'd1);
    send_byte(8'h7D);
    check("t1_cpu_rst_fall", 32'(a_cpu_rst), 32'd0);
    check("t1_words", 32'(a_wl), 32'd2);
    probe("t1_w0", 32'h0, 32'h7D00_0093, 32'h7D00_0093);
    probe("t1_w1", 32'h4, 32'h7D00_8093, 32'h7D00_8093);
    probe("t1_w2", 32'h8, NOP, NOP);

    // Empty image goes straight to RUN.
    do_reload();
    send_byte(8'h00); send_byte(8'h00);
    check("n0_done", 32'(a_load_done), 32'd1);
    probe("n0_f0", 32'h0, NOP, NOP);
    probe("n0_f4", 32'h4, NOP, NOP);

    // Five words: overflows the DEPTH=4 instance.
    do_reload();
    check("reload_cpu_rst", 32'(a_cpu_rst), 32'd1);
    check("reload_done",    32'(a_load_done), 32'd0);
    check("reload_ready",   32'(a_in_ready), 32'd1);
    words5[0] = 32'h1111_0001; words5[1] = 32'h2222_0002; words5[2] = 32'h3333_0003;
    words5[3] = 32'h4444_0004; words5[4] = 32'h5555_0005;
    send_byte(8'h05); send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_word(words5[i]);
    check("ovf_b_err",   32'(b_load_err), 32'd1);
    check("ovf_b_words", 32'(b_wl), 32'd4);
    check("ovf_b_done",  32'(b_load_done), 32'd1);
    check("ovf_a_err",   32'(a_load_err), 32'd0);
    check("ovf_a_words", 32'(a_wl), 32'd5);
    probe("ovf_far", 32'h302C, NOP, NOP);
    probe("ovf_w0", 32'h0, 32'h1111_0001, 32'h1111_0001);
    probe("ovf_w4", 32'h10, 32'h5555_0005, NOP);

    // Reload with a simultaneous byte: the byte must be dropped.
    reload = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    tick();
    reload = 1'b0; in_valid = 1'b0;
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h0200_8167);
    probe("rl_w0", 32'h0, 32'h0200_8167, 32'h0200_8167);
    probe("rl_w0m", 32'h2, 32'h0200_8167, 32'h0200_8167);

    // Reset after two data bytes, then a fresh load.
    do_reload();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    check("mid_rst_words", 32'(a_wl), 32'd0);
    check("mid_rst_ready", 32'(a_in_ready), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h1122_3344); send_word(32'hCAFE_F00D);
    probe("fresh_w0", 32'h0, 32'h1122_3344, 32'h1122_3344);
    probe("fresh_w1", 32'h4, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Randomized loads with gaps, aborts and junk traffic during RUN.
    for (int it = 0; it < 12; it++) begin
      int n;
      if ($urandom_range(0, 3) == 0) do_reset(); else do_reload();
      n = $urandom_range(0, 7);
      for (int k = 0; k < 2 + 4 * n; k++) begin
        logic [7:0] b;
        if (k == 0) b = 8'(n);
        else if (k == 1) b = 8'h00;
        else b = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
          imem_addr = rand_addr();
          in_data   = 8'($urandom);
          tick();
        end
        imem_addr = rand_addr();
        if ($urandom_range(0, 59) == 0) begin
          reload = 1'b1;
          in_valid = 1'b1;
          in_data = b;
          tick();
          reload = 1'b0;
          in_valid = 1'b0;
        end else begin
          send_byte(b);
        end
      end
      repeat (6) begin
        imem_addr = rand_addr();
        in_valid  = 1'($urandom);
        in_data   = 8'($urandom);
        tick();
      end
      in_valid = 1'b0;
    end

    tick();
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
